multicycle_control_unit: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 47 ++++
 rtl/multicycle_control_unit_decode.sv | 55 +++++
 rtl/multicycle_control_unit.sv | 133 +++++++++++++
 tb/tb_multicycle_control_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALUOp codes,
// FSM state encoding and the decoded control bundle.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_SHIFT = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_ANDI  = 4'h3;
  localparam logic [3:0] OP_LW    = 4'h4;
  localparam logic [3:0] OP_SW    = 4'h5;
  localparam logic [3:0] OP_BEQ   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP    = 3'd0,
    CL_ALU    = 3'd1,
    CL_LOAD   = 3'd2,
    CL_STORE  = 3'd3,
    CL_BRANCH = 3'd4,
    CL_HALT   = 3'd5
  } instr_class_t;

  // Select controls held from EXEC to the end of the instruction, plus its class.
  typedef struct packed {
    logic         reg_dst;
    logic         alu_src;
    logic         shift;
    logic         mem_to_reg;
    logic [1:0]   alu_op;
    instr_class_t cls;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_decode.sv
// Combinational opcode decoder: latched opcode -> select controls and
// instruction class used by the sequencing FSM.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl.reg_dst    = 1'b0;
    ctrl.alu_src    = 1'b0;
    ctrl.shift      = 1'b0;
    ctrl.mem_to_reg = 1'b0;
    ctrl.alu_op     = ALUOP_ADD;
    ctrl.cls        = CL_NOP;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_dst = 1'b1;
        ctrl.alu_op  = ALUOP_FUNCT;
        ctrl.cls     = CL_ALU;
      end
      OP_SHIFT: begin
        ctrl.reg_dst = 1'b1;
        ctrl.shift   = 1'b1;
        ctrl.cls     = CL_ALU;
      end
      OP_ADDI: begin
        ctrl.alu_src = 1'b1;
        ctrl.cls     = CL_ALU;
      end
      OP_ANDI: begin
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALUOP_AND;
        ctrl.cls     = CL_ALU;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.cls        = CL_LOAD;
      end
      OP_SW: begin
        ctrl.alu_src = 1'b1;
        ctrl.cls     = CL_STORE;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALUOP_SUB;
        ctrl.cls    = CL_BRANCH;
      end
      OP_HALT: ctrl.cls = CL_HALT;
      default: ctrl.cls = CL_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the 16-bit datapath: FETCH/EXEC/MEM/WB with
// wait-state memory, memory timeout trap, halt, and retired-instruction count.
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [3:0]       opcode,
  input  logic             MemReady,
  output logic             RegDst,
  output logic             Branch,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemToReg,
  output logic             ALUSrc,
  output logic             Shift,
  output logic [1:0]       ALUOp,
  output logic             PCWrite,
  output logic             Halted,
  output logic             Fault,
  output logic [CNT_W-1:0] RetiredCount,
  output logic [2:0]       State
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t           state_reg, state_next;
  logic [3:0]       op_q, op_next;
  logic [7:0]       wait_reg, wait_next;
  logic [CNT_W-1:0] retired_reg;
  ctrl_t            ctrl;

  ctrl_decode u_decode (
    .op   (op_q),
    .ctrl (ctrl)
  );

  always_comb begin
    state_next = state_reg;
    op_next    = op_q;
    wait_next  = 8'd0;
    RegDst     = 1'b0;
    Branch     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    MemToReg   = 1'b0;
    ALUSrc     = 1'b0;
    Shift      = 1'b0;
    ALUOp      = ALUOP_ADD;
    PCWrite    = 1'b0;
    Halted     = 1'b0;
    Fault      = 1'b0;

    // Selects stay stable for the whole life of the instruction after FETCH.
    if (state_reg == ST_EXEC || state_reg == ST_MEM || state_reg == ST_WB) begin
      RegDst   = ctrl.reg_dst;
      ALUSrc   = ctrl.alu_src;
      Shift    = ctrl.shift;
      MemToReg = ctrl.mem_to_reg;
      ALUOp    = ctrl.alu_op;
    end

    case (state_reg)
      ST_FETCH: begin
        op_next    = opcode;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        case (ctrl.cls)
          CL_BRANCH: begin
            Branch     = 1'b1;
            PCWrite    = 1'b1;
            state_next = ST_FETCH;
          end
          CL_NOP: begin
            PCWrite    = 1'b1;
            state_next = ST_FETCH;
          end
          CL_LOAD, CL_STORE: state_next = ST_MEM;
          CL_HALT:           state_next = ST_HALT;
          default:           state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        MemRead  = (ctrl.cls == CL_LOAD);
        MemWrite = (ctrl.cls == CL_STORE);
        if (MemReady) begin
          if (ctrl.cls == CL_LOAD) begin
            state_next = ST_WB;
          end else begin
            PCWrite    = 1'b1;
            state_next = ST_FETCH;
          end
        end else if (wait_reg + 8'd1 >= TIMEOUT_CNT) begin
          state_next = ST_FAULT;
        end else begin
          wait_next = wait_reg + 8'd1;
        end
      end
      ST_WB: begin
        RegWrite   = 1'b1;
        PCWrite    = 1'b1;
        state_next = ST_FETCH;
      end
      ST_HALT:  Halted = 1'b1;
      ST_FAULT: Fault  = 1'b1;
      default:  state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg   <= ST_FETCH;
      op_q        <= 4'h0;
      wait_reg    <= 8'd0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      op_q      <= op_next;
      wait_reg  <= wait_next;
      if (PCWrite) retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  assign RetiredCount = retired_reg;
  assign State        = state_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: random instruction streams compared against a
// per-instruction cycle-trace model built from the opcode map.
module tb_multicycle_control_unit;
  import cpu_ctrl_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int CW      = 8;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [3:0]    opcode;
  logic          MemReady;
  logic          RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, Shift;
  logic [1:0]    ALUOp;
  logic          PCWrite, Halted, Fault;
  logic [CW-1:0] RetiredCount;
  logic [2:0]    State;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CW-1:0] model_count;
  logic [12:0]   obs_vec;

  assign obs_vec = {RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg,
                    ALUSrc, Shift, ALUOp, PCWrite, Halted, Fault};

  always #5 Clock = ~Clock;

  multicycle_control_unit #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .Clock(Clock), .Reset(Reset), .opcode(opcode), .MemReady(MemReady),
    .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc), .Shift(Shift),
    .ALUOp(ALUOp), .PCWrite(PCWrite), .Halted(Halted), .Fault(Fault),
    .RetiredCount(RetiredCount), .State(State)
  );

  // {reg_dst, alu_src, shift, mem_to_reg, alu_op} straight from the opcode table
  function automatic logic [5:0] sel_of(input logic [3:0] op);
    case (op)
      4'h0:    return {1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
      4'h1:    return {1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
      4'h2:    return {1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      4'h3:    return {1'b0, 1'b1, 1'b0, 1'b0, 2'b11};
      4'h4:    return {1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
      4'h5:    return {1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      4'h6:    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
      default: return 6'b0;
    endcase
  endfunction

  function automatic logic [12:0] mk_vec(input logic [5:0] sel, input logic branch,
                                         input logic mem_read, input logic mem_write,
                                         input logic reg_write, input logic pc_write,
                                         input logic halted, input logic fault);
    return {sel[5], branch, mem_read, mem_write, reg_write, sel[2], sel[4], sel[3],
            sel[1:0], pc_write, halted, fault};
  endfunction

  // One instruction: w = MEM cycle on which MemReady rises; never_ready forces a timeout.
  task automatic exec_instr(input logic [3:0] op, input int w, input bit never_ready);
    int phases[$];
    int mem_k;
    bit is_lw, is_sw, is_beq, is_nop, is_alu;
    is_lw  = (op == 4'h4);
    is_sw  = (op == 4'h5);
    is_beq = (op == 4'h6);
    is_nop = (op >= 4'h7 && op <= 4'hE);
    is_alu = (op <= 4'h3);
    mem_k  = 0;
    phases = {0, 1};
    if (is_lw || is_sw) repeat (never_ready ? TIMEOUT : w) phases.push_back(2);
    if (is_alu || (is_lw && !never_ready)) phases.push_back(3);
    foreach (phases[i]) begin
      logic [12:0] exp_vec;
      logic [2:0]  exp_state;
      logic        rdy;
      rdy    = 1'($urandom_range(0, 1));
      opcode = 4'($urandom());
      case (phases[i])
        0: begin
          opcode    = op;
          exp_state = ST_FETCH;
          exp_vec   = '0;
        end
        1: begin
          exp_state = ST_EXEC;
          exp_vec   = mk_vec(sel_of(op), is_beq, 1'b0, 1'b0, 1'b0, is_beq || is_nop, 1'b0, 1'b0);
        end
        2: begin
          mem_k++;
          rdy       = !never_ready && (mem_k == w);
          exp_state = ST_MEM;
          exp_vec   = mk_vec(sel_of(op), 1'b0, is_lw, is_sw, 1'b0, is_sw && rdy, 1'b0, 1'b0);
        end
        default: begin
          exp_state = ST_WB;
          exp_vec   = mk_vec(sel_of(op), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
      endcase
      MemReady = rdy;
      #1;
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL ctrl op=%h phase=%0d cyc=%0d: got %b expected %b", op, phases[i], i, obs_vec, exp_vec);
      end
      n_checks++;
      if (State !== exp_state) begin
        n_fail++;
        $display("FAIL state op=%h cyc=%0d: got %0d expected %0d", op, i, State, exp_state);
      end
      if (exp_vec[2]) model_count++;
      @(posedge Clock); #1;
    end
    n_checks++;
    if (RetiredCount !== model_count) begin
      n_fail++;
      $display("FAIL retired op=%h: got %0d expected %0d", op, RetiredCount, model_count);
    end
    $display("instr op=%h wait=%0d timeout=%0d retired=%0d", op, w, never_ready, RetiredCount);
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    opcode   = 4'($urandom());
    MemReady = 1'($urandom_range(0, 1));
    @(posedge Clock); #1;
    Reset       = 1'b0;
    model_count = '0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) begin
      opcode   = 4'($urandom());
      MemReady = 1'($urandom_range(0, 1));
      @(posedge Clock); #1;
      n_checks++;
      if (obs_vec !== 13'b0 || State !== ST_FETCH || RetiredCount !== '0) begin
        n_fail++;
        $display("FAIL reset: got ctrl=%b state=%0d cnt=%0d expected 0/0/0", obs_vec, State, RetiredCount);
      end
    end
    Reset       = 1'b0;
    model_count = '0;
    $display("reset state=%0d cnt=%0d", State, RetiredCount);
  endtask

  task automatic test_addi();
    exec_instr(4'h2, 1, 1'b0);
    n_checks++;
    if (RetiredCount !== CW'(1)) begin
      n_fail++;
      $display("FAIL addi_count: got %0d expected 1", RetiredCount);
    end
  endtask

  task automatic test_lw();
    exec_instr(4'h4, 4, 1'b0);
    n_checks++;
    if (RetiredCount !== CW'(2)) begin
      n_fail++;
      $display("FAIL lw_count: got %0d expected 2", RetiredCount);
    end
  endtask

  task automatic test_mem_reset();
    exec_instr(4'h2, 1, 1'b0);
    opcode = 4'h4; MemReady = 1'b1;
    @(posedge Clock); #1;
    opcode = 4'hF; MemReady = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 1'b1;
    #1;
    n_checks++;
    if (MemRead !== 1'b1 || State !== ST_MEM) begin
      n_fail++;
      $display("FAIL mem2_before_reset: got MemRead=%b state=%0d expected 1/%0d", MemRead, State, ST_MEM);
    end
    @(posedge Clock); #1;
    n_checks++;
    if (MemRead !== 1'b0 || State !== ST_FETCH || RetiredCount !== '0) begin
      n_fail++;
      $display("FAIL mem_reset: got MemRead=%b state=%0d cnt=%0d expected 0/0/0", MemRead, State, RetiredCount);
    end
    Reset = 1'b0; model_count = '0;
    MemReady = 1'b1; opcode = 4'hA;
    #1;
    n_checks++;
    if (PCWrite !== 1'b0 || MemRead !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ready_fetch: got PCWrite=%b MemRead=%b expected 0/0", PCWrite, MemRead);
    end
    @(posedge Clock); #1;
    MemReady = 1'b0;
    #1;
    n_checks++;
    if (State !== ST_EXEC || PCWrite !== 1'b1 || MemRead !== 1'b0) begin
      n_fail++;
      $display("FAIL nop_after_reset: got state=%0d PCWrite=%b MemRead=%b expected %0d/1/0", State, PCWrite, MemRead, ST_EXEC);
    end
    @(posedge Clock); #1;
    model_count = CW'(1);
    n_checks++;
    if (RetiredCount !== CW'(1) || State !== ST_FETCH) begin
      n_fail++;
      $display("FAIL nop_retire: got cnt=%0d state=%0d expected 1/0", RetiredCount, State);
    end
    $display("mem_reset done cnt=%0d", RetiredCount);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++)
      exec_instr(4'($urandom_range(0, 14)), $urandom_range(1, 6), 1'b0);
    exec_instr(4'h4, TIMEOUT, 1'b0);
    exec_instr(4'h5, 1, 1'b0);
    exec_instr(4'h5, TIMEOUT, 1'b0);
  endtask

  task automatic test_beq_nop_halt();
    do_reset();
    exec_instr(4'h6, 1, 1'b0);
    exec_instr(4'hA, 1, 1'b0);
    exec_instr(4'hF, 1, 1'b0);
    for (int c = 0; c < 20; c++) begin
      opcode   = 4'($urandom());
      MemReady = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (obs_vec !== 13'b0_0000_0000_0010 || State !== ST_HALT) begin
        n_fail++;
        $display("FAIL halt_hold cyc=%0d: got ctrl=%b state=%0d expected halted only/%0d", c, obs_vec, State, ST_HALT);
      end
      @(posedge Clock); #1;
    end
    n_checks++;
    if (RetiredCount !== CW'(2)) begin
      n_fail++;
      $display("FAIL halt_count: got %0d expected 2", RetiredCount);
    end
    $display("halt hold done cnt=%0d", RetiredCount);
  endtask

  task automatic test_fault();
    do_reset();
    exec_instr(4'h5, 1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      opcode   = 4'($urandom());
      MemReady = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (obs_vec !== 13'b0_0000_0000_0001 || State !== ST_FAULT) begin
        n_fail++;
        $display("FAIL fault_hold cyc=%0d: got ctrl=%b state=%0d expected fault only/%0d", c, obs_vec, State, ST_FAULT);
      end
      @(posedge Clock); #1;
    end
    n_checks++;
    if (RetiredCount !== '0) begin
      n_fail++;
      $display("FAIL fault_count: got %0d expected 0", RetiredCount);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    while (model_count != '1)
      exec_instr(4'($urandom_range(6, 14)), 1, 1'b0);
    exec_instr(4'h7, 1, 1'b0);
    n_checks++;
    if (RetiredCount !== '0) begin
      n_fail++;
      $display("FAIL wrap: got %0d expected 0", RetiredCount);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset       = 1'b1;
    opcode      = 4'h0;
    MemReady    = 1'b0;
    model_count = '0;
    test_reset();
    test_addi();
    test_lw();
    test_mem_reset();
    test_random();
    test_beq_nop_halt();
    test_fault();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
